// File: rtl/sweep_sched.sv
// sweep_sched: bounded down/up triangle sweep sequencer with run count, pause and abort.
// Optional build macro SWEEP_SCHED_CNT_EN exposes the completed-sweep counter on cyc_cnt.
module sweep_sched #(
    parameter int W      = 4,
    parameter int NCYC_W = 8
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      lo,
    input  logic [W-1:0]      hi,
    input  logic [NCYC_W-1:0] ncyc,
    input  logic              pause,
    input  logic              stop,
    output logic [W-1:0]      x,
    output logic              dir,
    output logic              busy,
    output logic              done,
`ifdef SWEEP_SCHED_CNT_EN
    output logic              err,
    output logic [NCYC_W-1:0] cyc_cnt
`else
    output logic              err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DOWN,
        S_UP,
        S_DONE
    } state_t;

    localparam logic [W-1:0]      X_ONE   = W'(1);
    localparam logic [NCYC_W-1:0] CNT_ONE = NCYC_W'(1);

    state_t              state_reg, state_next;
    logic [W-1:0]        x_reg, x_next;
    logic                dir_reg, dir_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic [W-1:0]        lo_reg, lo_next;
    logic [W-1:0]        hi_reg, hi_next;
    logic [NCYC_W-1:0]   ncyc_reg, ncyc_next;
    logic [NCYC_W-1:0]   cnt_reg, cnt_next;
    logic [NCYC_W-1:0]   ncyc_last;

    // Index of the final sweep; only meaningful when ncyc_reg is non-zero.
    assign ncyc_last = ncyc_reg - CNT_ONE;

    always_ff @(posedge ck) begin
        if (rst) begin
            state_reg <= S_IDLE;
            x_reg     <= '0;
            dir_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            lo_reg    <= '0;
            hi_reg    <= '0;
            ncyc_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            dir_reg   <= dir_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            lo_reg    <= lo_next;
            hi_reg    <= hi_next;
            ncyc_reg  <= ncyc_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        dir_next   = dir_reg;
        err_next   = 1'b0;
        lo_next    = lo_reg;
        hi_next    = hi_reg;
        ncyc_next  = ncyc_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (lo <= hi) begin
                        lo_next    = lo;
                        hi_next    = hi;
                        ncyc_next  = ncyc;
                        cnt_next   = '0;
                        x_next     = hi;
                        dir_next   = 1'b0;
                        state_next = S_DOWN;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_DOWN: begin
                if (stop) begin
                    state_next = S_IDLE;
                end else if (!pause) begin
                    // The turnaround cycle repeats the bound so each sweep is 2*(hi-lo+1) long.
                    if (x_reg == lo_reg) begin
                        state_next = S_UP;
                        dir_next   = 1'b1;
                    end else begin
                        x_next = x_reg - X_ONE;
                    end
                end
            end
            S_UP: begin
                if (stop) begin
                    state_next = S_IDLE;
                end else if (!pause) begin
                    if (x_reg != hi_reg) begin
                        x_next = x_reg + X_ONE;
                    end else if ((ncyc_reg != '0) && (cnt_reg == ncyc_last)) begin
                        state_next = S_DONE;
                    end else begin
                        cnt_next   = cnt_reg + CNT_ONE;
                        dir_next   = 1'b0;
                        state_next = S_DOWN;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next == S_DOWN) || (state_next == S_UP);
        done_next = (state_next == S_DONE);
    end

    assign x    = x_reg;
    assign dir  = dir_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;
`ifdef SWEEP_SCHED_CNT_EN
    assign cyc_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_sweep_sched.sv
// Scoreboard bench for sweep_sched: per-cycle expected outputs are queued with the stimulus
// and popped against the DUT one cycle at a time.
module tb_sweep_sched;

    typedef struct packed {
        logic [3:0] x;
        logic       dir;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    logic       ck;
    logic       rst;
    logic       start;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] ncyc;
    logic       pause;
    logic       stop;
    logic [3:0] x;
    logic       dir;
    logic       busy;
    logic       done;
    logic       err;
`ifdef SWEEP_SCHED_CNT_EN
    logic [7:0] cyc_cnt;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    sweep_sched #(.W(4), .NCYC_W(8)) dut (
        .ck     (ck),
        .rst    (rst),
        .start  (start),
        .lo     (lo),
        .hi     (hi),
        .ncyc   (ncyc),
        .pause  (pause),
        .stop   (stop),
        .x      (x),
        .dir    (dir),
        .busy   (busy),
        .done   (done),
`ifdef SWEEP_SCHED_CNT_EN
        .err    (err),
        .cyc_cnt(cyc_cnt)
`else
        .err    (err)
`endif
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    function automatic exp_t mk(input int xv, input bit d, input bit b, input bit dn, input bit er);
        exp_t e;
        e.x    = 4'(xv);
        e.dir  = d;
        e.busy = b;
        e.done = dn;
        e.err  = er;
        return e;
    endfunction

    function automatic exp_t obs();
        return {x, dir, busy, done, err};
    endfunction

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    // Each sweep: hi down to lo with dir=0, then lo up to hi with dir=1.
    task automatic push_sweeps(input int l, input int h, input int n);
        for (int s = 0; s < n; s++) begin
            for (int v = h; v >= l; v--) exp_q.push_back(mk(v, 1'b0, 1'b1, 1'b0, 1'b0));
            for (int v = l; v <= h; v++) exp_q.push_back(mk(v, 1'b1, 1'b1, 1'b0, 1'b0));
        end
    endtask

    task automatic push_done(input int h);
        exp_q.push_back(mk(h, 1'b1, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(h, 1'b1, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; start = 1'b1; lo = 4'd3; hi = 4'd9; ncyc = 8'd5; pause = 1'b1; stop = 1'b1;
        step();
        step();
        e = mk(0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset: got %h required %h", obs(), e);
        end
`ifdef SWEEP_SCHED_CNT_EN
        n_checks++;
        if (cyc_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d required 0", cyc_cnt);
        end
`endif
        rst = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; lo = 4'd0; hi = 4'd0; ncyc = 8'd0;
        step();
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_idle: got %h required %h", obs(), e);
        end
        $display("test_reset: outputs idle after reset");
    endtask

    task automatic test_basic();
        exp_t e;
        int   idx = 0;
        lo = 4'd2; hi = 4'd5; ncyc = 8'd1; start = 1'b1;
        push_sweeps(2, 5, 1);
        push_done(5);
        step();
        start = 1'b0; lo = 4'd0; hi = 4'd0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL basic[%0d]: got x=%0d dir=%0b busy=%0b done=%0b err=%0b required x=%0d dir=%0b busy=%0b done=%0b err=%0b",
                         idx, x, dir, busy, done, err, e.x, e.dir, e.busy, e.done, e.err);
            end
            idx++;
            if (exp_q.size() > 0) step();
        end
`ifdef SWEEP_SCHED_CNT_EN
        n_checks++;
        if (cyc_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL basic_cnt: got %0d required 0", cyc_cnt);
        end
`endif
        $display("test_basic: lo=2 hi=5 ncyc=1, %0d cycles checked", idx);
    endtask

    task automatic test_continuous();
        exp_t e;
        lo = 4'd0; hi = 4'd15; ncyc = 8'd0; start = 1'b1;
        push_sweeps(0, 15, 2);
        step();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL cont[%0d]: got x=%0d dir=%0b busy=%0b done=%0b required x=%0d dir=%0b busy=%0b done=%0b",
                         i, x, dir, busy, done, e.x, e.dir, e.busy, e.done);
            end
            if (i == 39) stop = 1'b1;
            step();
        end
        stop = 1'b0;
        exp_q.delete();
        // Stop lands on the second sweep at x=8 going down; x holds, no done.
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(8, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL cont_stop[%0d]: got x=%0d dir=%0b busy=%0b done=%0b required x=%0d dir=%0b busy=%0b done=%0b",
                         k, x, dir, busy, done, e.x, e.dir, e.busy, e.done);
            end
            if (k < 3) step();
        end
`ifdef SWEEP_SCHED_CNT_EN
        n_checks++;
        if (cyc_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL cont_cnt: got %0d required 1", cyc_cnt);
        end
`endif
        $display("test_continuous: 40 sweep cycles then stop checked");
    endtask

    task automatic test_reject();
        exp_t e;
        int   idx = 0;
        lo = 4'd7; hi = 4'd3; ncyc = 8'd4; start = 1'b1;
        exp_q.push_back(mk(8, 1'b0, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(8, 1'b0, 1'b0, 1'b0, 1'b0));
        step();
        start = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL reject[%0d]: got x=%0d busy=%0b err=%0b required x=%0d busy=%0b err=%0b",
                         idx, x, busy, err, e.x, e.busy, e.err);
            end
            idx++;
            if (exp_q.size() > 0) step();
        end
        lo = 4'd3; hi = 4'd7; ncyc = 8'd2; start = 1'b1;
        push_sweeps(3, 7, 2);
        push_done(7);
        step();
        start = 1'b0;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL run2[%0d]: got x=%0d dir=%0b busy=%0b done=%0b err=%0b required x=%0d dir=%0b busy=%0b done=%0b err=%0b",
                         idx, x, dir, busy, done, err, e.x, e.dir, e.busy, e.done, e.err);
            end
            idx++;
            if (exp_q.size() > 0) step();
        end
        $display("test_reject: err pulse then lo=3 hi=7 ncyc=2 run, %0d cycles checked", idx);
    endtask

    task automatic test_flat();
        exp_t e;
        int   idx = 0;
        lo = 4'd9; hi = 4'd9; ncyc = 8'd3; start = 1'b1;
        push_sweeps(9, 9, 3);
        push_done(9);
        step();
        start = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL flat[%0d]: got x=%0d dir=%0b busy=%0b done=%0b required x=%0d dir=%0b busy=%0b done=%0b",
                         idx, x, dir, busy, done, e.x, e.dir, e.busy, e.done);
            end
`ifdef SWEEP_SCHED_CNT_EN
            if (e.done) begin
                n_checks++;
                if (cyc_cnt !== 8'd2) begin
                    n_fail++;
                    $display("FAIL flat_cnt_done: got %0d required 2", cyc_cnt);
                end
            end
`endif
            idx++;
            if (exp_q.size() > 0) step();
        end
`ifdef SWEEP_SCHED_CNT_EN
        n_checks++;
        if (cyc_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL flat_cnt_idle: got %0d required 2", cyc_cnt);
        end
`endif
        $display("test_flat: lo=hi=9 ncyc=3, %0d cycles checked", idx);
    endtask

    task automatic test_pause();
        exp_t e;
        int   idx = 0;
        lo = 4'd1; hi = 4'd6; ncyc = 8'd1; start = 1'b1;
        push_sweeps(1, 6, 1);
        for (int k = 0; k < 5; k++) exp_q.insert(3, mk(4, 1'b0, 1'b1, 1'b0, 1'b0));
        push_done(6);
        step();
        start = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL pause[%0d]: got x=%0d dir=%0b busy=%0b done=%0b required x=%0d dir=%0b busy=%0b done=%0b",
                         idx, x, dir, busy, done, e.x, e.dir, e.busy, e.done);
            end
            if (idx == 2) pause = 1'b1;
            if (idx == 7) pause = 1'b0;
            if (idx == 12) begin
                start = 1'b1; lo = 4'd0; hi = 4'd15; ncyc = 8'd0;
            end
            if (idx == 13) start = 1'b0;
            idx++;
            if (exp_q.size() > 0) step();
        end
        $display("test_pause: 5-cycle pause and ignored start, %0d cycles checked", idx);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   idx = 0;
        lo = 4'd0; hi = 4'd15; ncyc = 8'd1; start = 1'b1;
        push_sweeps(0, 15, 1);
        step();
        start = 1'b0;
        for (int i = 0; i < 27; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL rstmid[%0d]: got x=%0d dir=%0b busy=%0b required x=%0d dir=%0b busy=%0b",
                         i, x, dir, busy, e.x, e.dir, e.busy);
            end
            if (i == 26) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        exp_q.delete();
        e = mk(0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL rstmid_state: got %h required %h", obs(), e);
        end
`ifdef SWEEP_SCHED_CNT_EN
        n_checks++;
        if (cyc_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL rstmid_cnt: got %0d required 0", cyc_cnt);
        end
`endif
        lo = 4'd4; hi = 4'd5; ncyc = 8'd1; start = 1'b1;
        push_sweeps(4, 5, 1);
        push_done(5);
        step();
        start = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL after_rst[%0d]: got x=%0d dir=%0b busy=%0b done=%0b required x=%0d dir=%0b busy=%0b done=%0b",
                         idx, x, dir, busy, done, e.x, e.dir, e.busy, e.done);
            end
            idx++;
            if (exp_q.size() > 0) step();
        end
        $display("test_reset_mid: reset at x=10 then new run, %0d cycles checked", idx);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_continuous();
        test_reject();
        test_flat();
        test_pause();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sweep_sched.md
Name: sweep_sched

Overview:
Scheduler and sequencer for a bounded up/down (triangle) sweep counter. It latches a lower bound, upper bound and sweep count on a start request. It then drives the counter down from the upper bound to the lower bound and back up, repeating for the requested number of full sweeps, and reports completion. It sits between a control/host register block and any consumer of the sweep value, such as a DAC code or PWM compare value.

Parameters:
W, 4, width of sweep value and bounds
NCYC_W, 8, width of sweep-count request

Ports:
ck  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a new sweep run; sampled only in IDLE
lo  input  W  lower bound; latched when start accepted
hi  input  W  upper bound; latched when start accepted
ncyc  input  NCYC_W  number of full sweeps; 0 = run until stop; latched when start accepted
pause  input  1  freeze counter and state while high (DOWN/UP only)
stop  input  1  abort run; return to IDLE without done
x  output  W  sweep value (registered)
dir  output  1  0 = counting down, 1 = counting up (registered)
busy  output  1  high in DOWN and UP
done  output  1  one-cycle pulse on normal completion
err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Clock and reset: one clock `ck`; reset `rst` is synchronous and active-high. Only the rising edge of `ck` changes state.
- Reset values: state=IDLE, x=0, dir=0, busy=0, done=0, err=0, internal sweep counter=0, latched lo/hi/ncyc=0.
- Reset mid-run: same values on the next edge; the run is lost and no done pulse is produced.
- States: IDLE, DOWN, UP, DONE. All outputs are registered.
- IDLE, start=1 with lo<=hi: latch lo, hi, ncyc; clear sweep counter; x<=hi, dir<=0, next=DOWN.
- IDLE, start=1 with lo>hi: err=1 for one cycle; state, x and latches unchanged.
- IDLE otherwise: x holds its last value.
- DOWN: if x==lo then next=UP, dir<=1, x held for that cycle; else x<=x-1.
- UP, x!=hi: x<=x+1.
- UP, x==hi (end of one full sweep): if ncyc!=0 and counter==ncyc-1, go to DONE. Otherwise increment the counter (it wraps at 2^NCYC_W, matters only when ncyc=0), set dir<=0, next=DOWN, x held.
- DONE: done=1 for exactly this one cycle, busy=0, x holds hi; next=IDLE. start is ignored in DONE.
- Sweep period: one full sweep is 2*(hi-lo+1) cycles; lo==hi gives 2 cycles with x constant.
- x never leaves [lo,hi] while busy; no wrap-around of x is possible.
- pause=1 in DOWN/UP: x, dir, state and counter all hold. pause has no effect in IDLE or DONE.
- stop=1 in DOWN/UP: next=IDLE, x holds, no done pulse. stop takes priority over pause. stop has no effect in IDLE or DONE.
- start while busy is ignored. Changes to lo/hi/ncyc while busy have no effect.
- Priority: rst > stop > pause > normal sequencing.

Optional Feature:
- Macro: SWEEP_SCHED_CNT_EN.
- Defined: adds output port `cyc_cnt` (NCYC_W bits) carrying the completed-sweep counter. It is cleared on accepted start and on rst, and holds in IDLE/DONE.
- Not defined: the port is absent; the counter stays internal. All other behaviour is identical in both builds.

Test Plan:
- rst, then start lo=2 hi=5 ncyc=1 -> x=5,4,3,2,2,3,4,5 over 8 busy cycles with dir 0 for the first 4 and 1 for the last 4. Then done=1 for one cycle with x=5, then IDLE.
- start lo=0 hi=15 ncyc=0 -> continuous 32-cycle triangle 15..0,0..15. stop pulsed at cycle 40 -> IDLE next cycle, busy=0, done never asserted, x held.
- start lo=7 hi=3 -> err=1 for one cycle, busy stays 0, x unchanged. A following start lo=3 hi=7 ncyc=2 -> 20 busy cycles then done.
- lo=hi=9, ncyc=3 -> 6 busy cycles with x=9 throughout and dir toggling 0,1,0,1,0,1, then done. With SWEEP_SCHED_CNT_EN: cyc_cnt reads 2 at done (counter==ncyc-1) and holds 2 in IDLE.
- Run lo=1 hi=6 ncyc=1; pause high for 5 cycles at x=4 while counting down -> x and dir frozen, then resume at 3. Total busy cycles = 12+5. start pulsed during the run -> ignored.
- rst asserted mid-UP at x=10 -> next cycle x=0, busy=0, done=0, state IDLE. A new start is accepted on the following cycle.
